// File: rtl/dealer_pkg.sv
// dealer_pkg: deck constants, dealer state encoding and card decode helpers.
package dealer_pkg;
    localparam int NUM_CARDS = 52;
    localparam int RANKS     = 13;

    typedef enum logic [1:0] {IDLE, DRAW, SCAN, DONE} state_t;

    function automatic logic [3:0] idx_to_rank(input logic [5:0] idx);
        return 4'(idx % 6'(RANKS)) + 4'd1;
    endfunction

    function automatic logic [1:0] idx_to_suit(input logic [5:0] idx);
        return 2'(idx / 6'(RANKS));
    endfunction

    function automatic logic [3:0] rank_to_points(input logic [3:0] rank);
        return (rank == 4'd1) ? 4'd11 : (rank > 4'd10) ? 4'd10 : rank;
    endfunction
endpackage

// File: rtl/card_decode.sv
// card_decode: combinational deck index to rank, suit and Blackjack points.
module card_decode
    import dealer_pkg::*;
(
    input  logic [5:0] idx,
    output logic [3:0] rank,
    output logic [1:0] suit,
    output logic [3:0] points
);
    assign rank   = idx_to_rank(idx);
    assign suit   = idx_to_suit(idx);
    assign points = rank_to_points(rank);
endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals distinct cards from one 52-card deck using the LFSR word.
// Build option DEALER_AUTO_SHUFFLE_EN refills an empty deck on deal_req instead of raising deal_err.
module card_dealer
    import dealer_pkg::*;
#(
    parameter int MAX_TRIES = 8,
    parameter int RND_LSB   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rnd,
    input  logic        deal_req,
    input  logic        shuffle,
    output logic        card_valid,
    output logic [3:0]  card_rank,
    output logic [1:0]  card_suit,
    output logic [3:0]  card_points,
    output logic [5:0]  cards_left,
    output logic        busy,
    output logic        deal_err
);
    state_t      state_q, state_d;
    logic [51:0] used_q, used_d;
    logic [5:0]  cards_left_q, cards_left_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [3:0]  tries_q, tries_d;
    logic        card_valid_q, card_valid_d;
    logic [3:0]  card_rank_q, card_rank_d;
    logic [1:0]  card_suit_q, card_suit_d;
    logic [3:0]  card_points_q, card_points_d;
    logic        deal_err_q, deal_err_d;
    logic [5:0]  cand, cand_mod, hit_idx;
    logic [63:0] used_ext;
    logic        hit;
    logic [3:0]  dec_rank, dec_points;
    logic [1:0]  dec_suit;
    logic        rnd_unused;

    assign cand       = rnd[RND_LSB+5 -: 6];
    assign cand_mod   = (cand >= 6'(NUM_CARDS)) ? cand - 6'(NUM_CARDS) : cand;
    assign used_ext   = {12'd0, used_q};
    assign rnd_unused = ^rnd;

    card_decode u_decode (
        .idx    (hit_idx),
        .rank   (dec_rank),
        .suit   (dec_suit),
        .points (dec_points)
    );

    always_comb begin
        state_d      = state_q;
        used_d       = used_q;
        cards_left_d = cards_left_q;
        ptr_d        = ptr_q;
        tries_d      = tries_q;
        deal_err_d   = 1'b0;
        hit          = 1'b0;
        hit_idx      = ptr_q;
        case (state_q)
            IDLE: begin
                if (deal_req) begin
                    if (cards_left_q != 6'd0) begin
                        state_d = DRAW;
                        tries_d = 4'd0;
                    end else begin
`ifdef DEALER_AUTO_SHUFFLE_EN
                        used_d       = '0;
                        cards_left_d = 6'(NUM_CARDS);
                        state_d      = DRAW;
                        tries_d      = 4'd0;
`else
                        deal_err_d = 1'b1;
`endif
                    end
                end
            end
            DRAW: begin
                if (cand < 6'(NUM_CARDS) && !used_ext[cand]) begin
                    hit     = 1'b1;
                    hit_idx = cand;
                end else begin
                    tries_d = tries_q + 4'd1;
                    if (tries_q + 4'd1 == 4'(MAX_TRIES)) begin
                        state_d = SCAN;
                        ptr_d   = cand_mod;
                    end
                end
            end
            SCAN: begin
                if (!used_q[ptr_q]) hit = 1'b1;
                else ptr_d = (ptr_q == 6'(NUM_CARDS - 1)) ? 6'd0 : ptr_q + 6'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (hit) begin
            state_d          = DONE;
            used_d[hit_idx]  = 1'b1;
            cards_left_d     = cards_left_q - 6'd1;
        end
        // Shuffle overrides everything, including a hit in the same cycle.
        if (shuffle) begin
            state_d      = IDLE;
            used_d       = '0;
            cards_left_d = 6'(NUM_CARDS);
            deal_err_d   = 1'b0;
        end
        card_valid_d  = hit && !shuffle;
        card_rank_d   = card_valid_d ? dec_rank   : card_rank_q;
        card_suit_d   = card_valid_d ? dec_suit   : card_suit_q;
        card_points_d = card_valid_d ? dec_points : card_points_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            used_q        <= '0;
            cards_left_q  <= 6'(NUM_CARDS);
            ptr_q         <= 6'd0;
            tries_q       <= 4'd0;
            card_valid_q  <= 1'b0;
            card_rank_q   <= 4'd0;
            card_suit_q   <= 2'd0;
            card_points_q <= 4'd0;
            deal_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            used_q        <= used_d;
            cards_left_q  <= cards_left_d;
            ptr_q         <= ptr_d;
            tries_q       <= tries_d;
            card_valid_q  <= card_valid_d;
            card_rank_q   <= card_rank_d;
            card_suit_q   <= card_suit_d;
            card_points_q <= card_points_d;
            deal_err_q    <= deal_err_d;
        end
    end

    assign card_valid  = card_valid_q;
    assign card_rank   = card_rank_q;
    assign card_suit   = card_suit_q;
    assign card_points = card_points_q;
    assign cards_left  = cards_left_q;
    assign busy        = (state_q != IDLE);
    assign deal_err    = deal_err_q;
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed scoreboard bench for card_dealer.
module tb_card_dealer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rnd = 16'h0000;
    logic        deal_req = 1'b0;
    logic        shuffle = 1'b0;
    logic        card_valid;
    logic [3:0]  card_rank;
    logic [1:0]  card_suit;
    logic [3:0]  card_points;
    logic [5:0]  cards_left;
    logic        busy;
    logic        deal_err;

    int nchecks = 0;
    int nerr = 0;

    typedef struct {
        int rank;
        int suit;
        int pts;
    } card_t;

    card_t sb[$];
    bit    seen[52];

    card_dealer #(.MAX_TRIES(8), .RND_LSB(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .rnd         (rnd),
        .deal_req    (deal_req),
        .shuffle     (shuffle),
        .card_valid  (card_valid),
        .card_rank   (card_rank),
        .card_suit   (card_suit),
        .card_points (card_points),
        .cards_left  (cards_left),
        .busy        (busy),
        .deal_err    (deal_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_card(input int rank, input int suit, input int pts);
        card_t c;
        c.rank = rank;
        c.suit = suit;
        c.pts  = pts;
        sb.push_back(c);
    endtask

    task automatic do_shuffle();
        @(negedge clk);
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
    endtask

    task automatic do_deal(input logic [15:0] r, input bit fr, output int lat, output bit got, output bit err);
        card_t e;
        @(negedge clk);
        rnd = r;
        deal_req = 1'b1;
        lat = 0;
        got = 1'b0;
        err = 1'b0;
        while (!got && !err && lat < 120) begin
            @(negedge clk);
            deal_req = 1'b0;
            if (fr) rnd = 16'($urandom);
            lat++;
            got = card_valid;
            err = deal_err;
        end
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            chk("card_rank", card_rank, e.rank);
            chk("card_suit", card_suit, e.suit);
            chk("card_points", card_points, e.pts);
        end
        sb.delete();
    endtask

    initial begin
        int  lat;
        bit  got;
        bit  err;
        int  idx;
        int  exp_pts;
        bit  saw;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_cards_left", cards_left, 52);
        chk("rst_valid", card_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", deal_err, 0);
        chk("rst_rank", card_rank, 0);

        push_card(1, 0, 11);
        do_deal(16'h0000, 1'b0, lat, got, err);
        chk("first_got", got, 1);
        chk("first_lat", lat, 2);
        chk("first_left", cards_left, 51);
        @(negedge clk);
        chk("first_valid_drop", card_valid, 0);
        chk("first_rank_hold", card_rank, 1);
        chk("first_busy_idle", busy, 0);

        do_shuffle();
        chk("shuf_left", cards_left, 52);
        push_card(12, 0, 10);
        do_deal(16'h003F, 1'b0, lat, got, err);
        chk("scan_got", got, 1);
        chk("scan_lat", lat, 10);

        do_shuffle();
        push_card(1, 0, 11);
        do_deal(16'h0000, 1'b0, lat, got, err);
        chk("dup_first_got", got, 1);
        push_card(2, 0, 2);
        do_deal(16'h0000, 1'b0, lat, got, err);
        chk("dup_second_got", got, 1);
        chk("dup_lat", lat, 11);
        chk("dup_left", cards_left, 50);

        do_shuffle();
        @(negedge clk);
        rnd = 16'h003F;
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        chk("abort_busy_draw", busy, 1);
        @(negedge clk);
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_left", cards_left, 52);
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw = saw | card_valid;
        end
        chk("abort_no_valid", saw, 0);

        do_deal(16'h0005, 1'b0, lat, got, err);
        chk("pre_sd_left", cards_left, 51);
        @(negedge clk);
        shuffle = 1'b1;
        deal_req = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        deal_req = 1'b0;
        chk("sd_busy", busy, 0);
        chk("sd_left", cards_left, 52);
        @(negedge clk);
        chk("sd_no_valid", card_valid, 0);
        chk("sd_busy2", busy, 0);

        do_shuffle();
        for (int i = 0; i < 52; i++) begin
            do_deal(16'($urandom), 1'b1, lat, got, err);
            chk("exh_got", got, 1);
            idx = int'(card_suit) * 13 + int'(card_rank) - 1;
            chk("exh_distinct", (idx >= 0 && idx < 52) ? int'(seen[idx]) : 1, 0);
            if (idx >= 0 && idx < 52) seen[idx] = 1'b1;
            exp_pts = (card_rank == 4'd1) ? 11 : (card_rank > 4'd10) ? 10 : int'(card_rank);
            chk("exh_points", card_points, exp_pts);
            chk("exh_left", cards_left, 51 - i);
        end
        chk("exh_empty", cards_left, 0);

        push_card(1, 0, 11);
        do_deal(16'h0000, 1'b0, lat, got, err);
`ifdef DEALER_AUTO_SHUFFLE_EN
        chk("auto_got", got, 1);
        chk("auto_err", err, 0);
        chk("auto_left", cards_left, 51);
`else
        chk("empty_err", err, 1);
        chk("empty_got", got, 0);
        chk("empty_lat", lat, 1);
        chk("empty_left", cards_left, 0);
        @(negedge clk);
        chk("empty_err_drop", deal_err, 0);
        chk("empty_busy", busy, 0);
`endif

        do_shuffle();
        @(negedge clk);
        rnd = 16'h003F;
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_left", cards_left, 52);
        chk("arst_rank", card_rank, 0);
        chk("arst_points", card_points, 0);
        chk("arst_valid", card_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw = saw | card_valid;
        end
        chk("arst_no_valid", saw, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
